// File: rtl/fft_polar_to_complex.sv
// Polar (magnitude, phase) to I/Q converter: iterative CORDIC in rotation mode, one micro-rotation per cycle.
// Latency ITERS+2 cycles from the accept edge to out_valid; a single sample is in flight, and in_ready stays low until the result is consumed.
module fft_polar_to_complex #(
    parameter int unsigned ITERS = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] comp_m,
    input  logic [15:0] comp_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] comp_i,
    output logic [15:0] comp_q
);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_ROT, S_HOLD} state_t;

    localparam logic [4:0] K_DONE = 5'(ITERS);

    state_t             state_q, state_d;
    logic [4:0]         k_q, k_d;
    logic signed [18:0] x_q, x_d, y_q, y_d;
    logic signed [16:0] z_q, z_d;
    logic [15:0]        m_q, m_d, p_q, p_d;
    logic [15:0]        ci_q, ci_d, cq_q, cq_d;
    logic               ov_q, ov_d;

    logic [16:0]        x0;
    logic signed [18:0] x0_s, x_sh, y_sh;
    logic signed [16:0] ang;

    function automatic logic [13:0] atan_lut(input logic [4:0] k);
        case (k)
            5'd0:    atan_lut = 14'd8192;
            5'd1:    atan_lut = 14'd4836;
            5'd2:    atan_lut = 14'd2555;
            5'd3:    atan_lut = 14'd1297;
            5'd4:    atan_lut = 14'd651;
            5'd5:    atan_lut = 14'd326;
            5'd6:    atan_lut = 14'd163;
            5'd7:    atan_lut = 14'd81;
            5'd8:    atan_lut = 14'd41;
            5'd9:    atan_lut = 14'd20;
            5'd10:   atan_lut = 14'd10;
            5'd11:   atan_lut = 14'd5;
            5'd12:   atan_lut = 14'd3;
            5'd13:   atan_lut = 14'd1;
            5'd14:   atan_lut = 14'd1;
            default: atan_lut = 14'd0;
        endcase
    endfunction

    // Clamp symmetrically so a large magnitude never wraps to the opposite sign.
    function automatic logic [15:0] sat16(input logic signed [18:0] v);
        if (v > 19'sd32767)
            sat16 = 16'h7FFF;
        else if (v < -19'sd32767)
            sat16 = 16'h8001;
        else
            sat16 = v[15:0];
    endfunction

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        m_d     = m_q;
        p_d     = p_q;
        ci_d    = ci_q;
        cq_d    = cq_q;
        ov_d    = ov_q;
        x0      = 17'(({16'b0, m_q} * 32'd19898) >> 15);
        x0_s    = {2'b00, x0};
        x_sh    = x_q >>> k_q;
        y_sh    = y_q >>> k_q;
        ang     = {3'b000, atan_lut(k_q)};

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    m_d     = comp_m;
                    p_d     = comp_p;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                // Quadrant pre-rotation leaves a residual angle in [0, 90 deg).
                case (p_q[15:14])
                    2'b00:   begin x_d = x0_s;  y_d = '0;    end
                    2'b01:   begin x_d = '0;    y_d = x0_s;  end
                    2'b10:   begin x_d = -x0_s; y_d = '0;    end
                    default: begin x_d = '0;    y_d = -x0_s; end
                endcase
                z_d     = {3'b000, p_q[13:0]};
                k_d     = '0;
                state_d = S_ROT;
            end
            S_ROT: begin
                if (k_q == K_DONE) begin
                    ci_d    = sat16(x_q);
                    cq_d    = sat16(y_q);
                    ov_d    = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    if (!z_q[16]) begin
                        x_d = x_q - y_sh;
                        y_d = y_q + x_sh;
                        z_d = z_q - ang;
                    end else begin
                        x_d = x_q + y_sh;
                        y_d = y_q - x_sh;
                        z_d = z_q + ang;
                    end
                    k_d = k_q + 5'd1;
                end
            end
            default: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            m_q     <= '0;
            p_q     <= '0;
            ci_q    <= '0;
            cq_q    <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            m_q     <= m_d;
            p_q     <= p_d;
            ci_q    <= ci_d;
            cq_q    <= cq_d;
            ov_q    <= ov_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = ov_q;
    assign comp_i    = ci_q;
    assign comp_q    = cq_q;

endmodule
